// File: rtl/seq_tx_pkg.sv
// rtl/seq_tx_pkg.sv - shared state encoding and default sizing for the run-length transmitter
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } seq_tx_state_e;

  localparam int DEF_LEN_W   = 4;
  localparam int DEF_GAP     = 2;
  localparam int DEF_DET_LEN = 4;
  localparam int DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - run-length command handshake between a command source and the transmitter
interface seq_pattern_tx_if #(
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic [LEN_W-1:0] in_len;
  logic             in_ready;

  modport master (output in_valid, output in_len, input in_ready);
  modport slave  (input in_valid, input in_len, output in_ready);
endinterface

// File: rtl/seq_hit_model.sv
// rtl/seq_hit_model.sv - model of the far-end 1-run detector driven by the transmitted bit stream
// Ones accumulate across zeros; reaching the threshold point clears the model whatever the bit.
module seq_hit_model
  import seq_tx_pkg::*;
#(
  parameter int DET_LEN = DEF_DET_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             aout,
  output logic             exp_hit,
  output logic [CNT_W-1:0] count
);

  localparam int             M_W   = $clog2(DET_LEN);
  localparam logic [M_W-1:0] M_TOP = M_W'(DET_LEN - 1);

  logic [M_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             at_top;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q     <= '0;
      count_q <= '0;
    end else begin
      m_q     <= m_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    at_top  = (m_q == M_TOP);
    exp_hit = aout && at_top;
    m_d     = m_q;
    if (at_top) begin
      m_d = '0;
    end else if (aout) begin
      m_d = m_q + M_W'(1);
    end
    count_d = count_q + CNT_W'(exp_hit);
  end

  assign count = count_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serialises run-length commands as N ones then GAP zeros, tracking expected detector hits
// Optional abort input is built when SEQ_TX_ABORT_EN is defined.
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int LEN_W   = DEF_LEN_W,
  parameter int GAP     = DEF_GAP,
  parameter int DET_LEN = DEF_DET_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  cmd,
`ifdef SEQ_TX_ABORT_EN
  input  logic             abort,
`endif
  output logic             aout,
  output logic             busy,
  output logic             done,
  output logic             exp_hit,
  output logic [CNT_W-1:0] count,
  output logic [3:0]       led
);

  localparam logic [3:0] GAP_LOAD = 4'(GAP);

  seq_tx_state_e    state_q, state_d;
  logic [LEN_W-1:0] run_cnt_q, run_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             aout_q;
  logic [3:0]       led_q;
  logic             accept;
  logic             abort_run;

  assign accept = cmd.in_valid && (state_q == ST_IDLE);

`ifdef SEQ_TX_ABORT_EN
  assign abort_run = abort;
`else
  assign abort_run = 1'b0;
`endif

  // aout is registered from the next state so the first one lands right after the accept edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      run_cnt_q <= '0;
      gap_cnt_q <= '0;
      aout_q    <= 1'b0;
      led_q     <= '0;
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      aout_q    <= (state_d == ST_RUN);
      led_q     <= count[3:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (cmd.in_len != '0) begin
            state_d   = ST_RUN;
            run_cnt_d = cmd.in_len;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      ST_RUN: begin
        if ((run_cnt_q == LEN_W'(1)) || abort_run) begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          run_cnt_d = run_cnt_q - LEN_W'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd1) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd.in_ready = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_GAP) && (gap_cnt_q == 4'd1);
  end

  seq_hit_model #(
    .DET_LEN (DET_LEN),
    .CNT_W   (CNT_W)
  ) u_hit_model (
    .clk     (clk),
    .reset   (reset),
    .aout    (aout_q),
    .exp_hit (exp_hit),
    .count   (count)
  );

  assign aout = aout_q;
  assign led  = led_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - directed self-checking bench for seq_pattern_tx with default parameters
module tb_seq_pattern_tx;

  logic       clk;
  logic       reset;
  logic       aout, busy, done, exp_hit;
  logic [7:0] count;
  logic [3:0] led;
`ifdef SEQ_TX_ABORT_EN
  logic       abort;
`endif

  int n_pass  = 0;
  int n_total = 0;

  seq_pattern_tx_if #(.LEN_W(4)) ifc ();

  seq_pattern_tx dut (
    .clk     (clk),
    .reset   (reset),
    .cmd     (ifc),
`ifdef SEQ_TX_ABORT_EN
    .abort   (abort),
`endif
    .aout    (aout),
    .busy    (busy),
    .done    (done),
    .exp_hit (exp_hit),
    .count   (count),
    .led     (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_len   = '0;
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
  endtask

  task automatic issue(input logic [3:0] len);
    int k = 0;
    while (!ifc.in_ready && k < 50) begin
      step();
      k++;
    end
    if (k == 50) begin
      n_total++;
      $display("FAIL issue_timeout in_ready stuck at %b want 1", ifc.in_ready);
    end
    ifc.in_valid = 1'b1;
    ifc.in_len   = len;
    step();
    ifc.in_valid = 1'b0;
  endtask

  // bit i of each vector is the value seen i cycles after the accept edge
  task automatic capture(input int n, output logic [31:0] a, output logic [31:0] h,
                         output logic [31:0] d, output logic [31:0] r, output logic [31:0] b);
    a = '0; h = '0; d = '0; r = '0; b = '0;
    for (int i = 0; i < n; i++) begin
      a[i] = aout;
      h[i] = exp_hit;
      d[i] = done;
      r[i] = ifc.in_ready;
      b[i] = busy;
      step();
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_len   = '0;
    #3;
    n_total++;
    if ({aout, busy, done, exp_hit} !== 4'b0000) $display("FAIL reset_outs got %b want 0000", {aout, busy, done, exp_hit});
    else n_pass++;
    n_total++;
    if (count !== 8'd0 || led !== 4'd0) $display("FAIL reset_count got %0d/%0d want 0/0", count, led);
    else n_pass++;
    n_total++;
    if (ifc.in_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ifc.in_ready);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [31:0] a, h, d, r, b;
    do_reset();
    issue(4'd4);
    capture(6, a, h, d, r, b);
    n_total++;
    if (a[5:0] !== 6'b001111) $display("FAIL basic_aout got %b want 001111", a[5:0]);
    else n_pass++;
    n_total++;
    if (h[5:0] !== 6'b001000) $display("FAIL basic_hit got %b want 001000", h[5:0]);
    else n_pass++;
    n_total++;
    if (d[5:0] !== 6'b100000) $display("FAIL basic_done got %b want 100000", d[5:0]);
    else n_pass++;
    n_total++;
    if (b[5:0] !== 6'b111111 || r[5:0] !== 6'b000000) $display("FAIL basic_busy got busy=%b ready=%b want 111111/000000", b[5:0], r[5:0]);
    else n_pass++;
    n_total++;
    if (count !== 8'd1 || led !== 4'd1 || ifc.in_ready !== 1'b1) $display("FAIL basic_end got count=%0d led=%0d ready=%b want 1/1/1", count, led, ifc.in_ready);
    else n_pass++;
  endtask

  task automatic test_persist();
    logic [31:0] a, h, d, r, b;
    logic [31:0] hits;
    do_reset();
    hits = '0;
    issue(4'd3);
    capture(5, a, h, d, r, b);
    hits |= h;
    issue(4'd1);
    capture(3, a, h, d, r, b);
    hits |= h;
    n_total++;
    if (a[2:0] !== 3'b001) $display("FAIL persist_len1_aout got %b want 001", a[2:0]);
    else n_pass++;
    issue(4'd2);
    capture(4, a, h, d, r, b);
    hits |= h;
    issue(4'd2);
    capture(4, a, h, d, r, b);
    hits |= h;
    n_total++;
    if (hits !== 32'd0 || count !== 8'd0) $display("FAIL persist_count got hits=%h count=%0d want 0/0", hits, count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, h, d, r, b;
    do_reset();
    ifc.in_valid = 1'b1;
    ifc.in_len   = 4'd2;
    step();
    ifc.in_len = 4'd3;
    capture(10, a, h, d, r, b);
    ifc.in_valid = 1'b0;
    n_total++;
    if (a[9:0] !== 10'b0011100011) $display("FAIL b2b_aout got %b want 0011100011", a[9:0]);
    else n_pass++;
    n_total++;
    if (d[9:0] !== 10'b1000001000 || r[9:0] !== 10'b0000010000) $display("FAIL b2b_done got done=%b ready=%b want 1000001000/0000010000", d[9:0], r[9:0]);
    else n_pass++;
    n_total++;
    if (h[9:0] !== 10'b0001000000 || count !== 8'd1) $display("FAIL b2b_hit got %b count=%0d want 0001000000/1", h[9:0], count);
    else n_pass++;
  endtask

  task automatic test_long_run();
    logic [31:0] a, h, d, r, b;
    do_reset();
    issue(4'd15);
    capture(17, a, h, d, r, b);
    n_total++;
    if (a[16:0] !== 17'h07fff) $display("FAIL long_aout got %h want 07fff", a[16:0]);
    else n_pass++;
    n_total++;
    if (h[16:0] !== 17'h00888 || d[16:0] !== 17'h10000) $display("FAIL long_hit got hit=%h done=%h want 00888/10000", h[16:0], d[16:0]);
    else n_pass++;
    n_total++;
    if (count !== 8'd3) $display("FAIL long_count got %0d want 3", count);
    else n_pass++;
    issue(4'd1);
    capture(3, a, h, d, r, b);
    n_total++;
    if (count !== 8'd3 || h[2:0] !== 3'b000) $display("FAIL long_gap_clear got count=%0d hit=%b want 3/000", count, h[2:0]);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    logic [31:0] a, h, d, r, b;
    do_reset();
    issue(4'd0);
    capture(3, a, h, d, r, b);
    n_total++;
    if (a[2:0] !== 3'b000 || d[2:0] !== 3'b010) $display("FAIL zero_aout got aout=%b done=%b want 000/010", a[2:0], d[2:0]);
    else n_pass++;
    n_total++;
    if (b[2:0] !== 3'b011 || r[2:0] !== 3'b100 || count !== 8'd0) $display("FAIL zero_busy got busy=%b ready=%b count=%0d want 011/100/0", b[2:0], r[2:0], count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] a, h, d, r, b;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      issue(4'd4);
      capture(6, a, h, d, r, b);
    end
    n_total++;
    if (count !== 8'd255 || led !== 4'hf) $display("FAIL wrap_preload got count=%0d led=%0d want 255/15", count, led);
    else n_pass++;
    issue(4'd4);
    capture(6, a, h, d, r, b);
    n_total++;
    if (count !== 8'd0 || led !== 4'd0) $display("FAIL wrap_rollover got count=%0d led=%0d want 0/0", count, led);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] a, h, d, r, b;
    do_reset();
    issue(4'd8);
    step();
    n_total++;
    if (aout !== 1'b1) $display("FAIL midrst_pre got aout=%b want 1", aout);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (aout !== 1'b0 || ifc.in_ready !== 1'b1 || busy !== 1'b0 || count !== 8'd0) $display("FAIL midrst_now got aout=%b ready=%b busy=%b count=%0d want 0/1/0/0", aout, ifc.in_ready, busy, count);
    else n_pass++;
    #1 reset = 1'b1;
    step();
    capture(10, a, h, d, r, b);
    n_total++;
    if (a[9:0] !== 10'd0 || d[9:0] !== 10'd0) $display("FAIL midrst_after got aout=%b done=%b want all 0", a[9:0], d[9:0]);
    else n_pass++;
  endtask

`ifdef SEQ_TX_ABORT_EN
  task automatic test_abort();
    logic [7:0] a, d;
    do_reset();
    abort = 1'b1;
    issue(4'd8);
    a = '0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      abort = (i == 2);
      a[i]  = aout;
      d[i]  = done;
      step();
    end
    abort = 1'b0;
    n_total++;
    if (a !== 8'b00000111) $display("FAIL abort_aout got %b want 00000111", a);
    else n_pass++;
    n_total++;
    if (d !== 8'b00010000) $display("FAIL abort_done got %b want 00010000", d);
    else n_pass++;
  endtask
`endif

  initial begin
`ifdef SEQ_TX_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_persist();
    test_back_to_back();
    test_long_run();
    test_zero_len();
    test_wrap();
    test_reset_mid_run();
`ifdef SEQ_TX_ABORT_EN
    test_abort();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Transmit-side counterpart of the team's serial 1-run detector.
- Accepts run-length commands over a valid/ready handshake and serialises each one onto a single-bit line `aout`: N ones followed by GAP zeros.
- Runs an internal model of the detector so the bench and LEDs can see, cycle for cycle, how many detections the far end should report.

Parameters:
- LEN_W, 4, width of the run-length command; max run is 2^LEN_W-1.
- GAP, 2, number of zero bits after each run; legal range 1..15.
- DET_LEN, 4, detector threshold (number of counted ones per hit); legal range 2..16.
- CNT_W, 8, width of the expected-hit counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_len  in  LEN_W  number of ones to send.
- in_ready  out  1  command accepted when in_valid && in_ready.
- aout  out  1  serial bit stream, registered.
- busy  out  1  high in RUN or GAP.
- done  out  1  one-cycle pulse on the last GAP bit.
- exp_hit  out  1  high in the cycle whose aout bit should make the detector fire.
- count  out  CNT_W  running total of expected hits.
- led  out  4  count[3:0], registered.

Behaviour:
- Reset (reset=0, async) clears the following, with no glitch on release:
  - state=IDLE, aout=0, busy=0, done=0, exp_hit=0, count=0, led=0, model state m=0, in_ready=1.
- FSM states IDLE, RUN, GAP.
- IDLE:
  - in_ready=1, aout=0.
  - On accept with in_len>0: load run counter=in_len and go to RUN.
  - On accept with in_len=0: go to GAP; no ones are sent.
- RUN:
  - aout=1 for exactly in_len cycles, starting the cycle after the accept edge.
  - Then go to GAP.
- GAP:
  - aout=0 for exactly GAP cycles.
  - done=1 on the last of these cycles, then go to IDLE.
- in_ready is 0 in RUN and GAP. At least one IDLE cycle (aout=0) always separates consecutive commands.
- in_valid while busy is ignored; in_len is sampled only at the accept edge.
- Detector model, m in 0..DET_LEN-1, evaluated each cycle on the current aout:
  - aout=1 and m=DET_LEN-1: exp_hit=1, m<=0.
  - aout=1 otherwise: m<=m+1.
  - aout=0 and m=DET_LEN-1: m<=0.
  - aout=0 otherwise: m holds.
  - So ones accumulate across zeros except at the threshold-minus-one point.
  - m persists across commands; only reset clears it.
- exp_hit is combinational from the registered aout and m. It is therefore aligned with the detector's Mealy output in the same cycle.
- count increments by 1 on every exp_hit and wraps modulo 2^CNT_W, with no saturation.
- led updates one cycle after count.
- Reset asserted mid-RUN or mid-GAP:
  - Immediate return to IDLE with aout=0.
  - The partial command is dropped and no done pulse is generated.

Optional Feature:
- Macro SEQ_TX_ABORT_EN.
- When defined:
  - Adds input port `abort` (1 bit).
  - abort=1 in RUN ends the run at the next edge (aout=0) and goes to GAP with the full GAP count. done still pulses at the end of GAP.
  - abort in IDLE or GAP has no effect.
  - If abort and the accept coincide in IDLE, the accept wins.
- When undefined: no abort port, and every run completes.

Decomposition:
- Package seq_tx_pkg holds:
  - The state enum (IDLE/RUN/GAP).
  - Default constants for LEN_W, GAP, DET_LEN, CNT_W.
- Sub-module seq_hit_model holds m, exp_hit and count, with inputs clk, reset and aout. It is reusable by the bench as a scoreboard.

Test Plan:
- Reset, then in_len=4 → aout=1 for 4 cycles then 0 for 2; exp_hit in the 4th one-cycle; count=1; done after the 2nd zero; led=1.
- in_len=3, then in_len=1 (m persists at 3, then the 0 in the gap resets it) → count stays 0.
  - Then in_len=2, in_len=2 → count still 0, because the gap after the first command resets m again.
- in_len=15 → hits on one-cycles 4, 8, 12; count=3; m=3 at run end, cleared by the following gap.
- in_len=0 → aout held 0 for GAP cycles, done pulses, count unchanged.
- Preload count=255 (issue 255 len=4 commands), then one more → count wraps to 0, led=0.
- Reset pulse during the 2nd one of in_len=8 → aout=0 at once, in_ready=1, count=0, no done.
  - With SEQ_TX_ABORT_EN: abort at the 3rd one of in_len=8 → exactly 3 ones sent, then 2 zeros and done.
